seven_segment_reader: RTL and testbench

- Receive-side counterpart of the BCD-to-seven-segment decoder. Samples a time-multiplexed seven-segment bus (segment lines plus one-hot digit enables) and recovers a BCD value per digit.
- Sits between an external or emulated display driver and logic or checkers that need numeric values. Intended use: loopback self-test of display paths, and scraping of legacy panels.
- Sequential: input registration, a stability filter, a per-digit capture register file and frame completion tracking.

---
 rtl/seven_segment_pkg.sv | 35 +++
 rtl/seg_pattern_decode.sv | 30 +++
 rtl/seven_segment_reader.sv | 135 +++++++++++++
 tb/tb_seven_segment_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment bus reader: segment patterns,
// FSM states and one-hot helpers.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    // Digit enables are zero-extended to 8 bits, the widest supported bus.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder; blank and unknown
// patterns both yield BCD_INVALID, only unknown ones flag err.
module seg_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_INVALID;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a multiplexed seven-segment bus and recovers one BCD value per digit.
// Define SEG_ACTIVE_LOW_EN to invert seg/dig_en at the input (common-anode panels).
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   pat_err,
    output logic                    onehot_err,
    output logic                    frame_done
);

    localparam logic [7:0] CNT_TARGET = 8'(STABLE_CYCLES);

    logic [6:0]            seg_in, s_seg, p_seg;
    logic [NUM_DIGITS-1:0] en_in, s_en, p_en;
    logic [7:0]            cnt;
    logic [7:0]            en8;
    logic                  same, en_onehot, en_multi, capture;
    logic [2:0]            cap_idx;
    logic [3:0]            dec_bcd;
    logic                  dec_err;
    logic [NUM_DIGITS-1:0] frame_mask, mask_upd;
    state_t                state, state_nxt;

    always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
        seg_in = ~seg;
        en_in  = ~dig_en;
`else
        seg_in = seg;
        en_in  = dig_en;
`endif
    end

    // Input stage: registered sample plus the previous sample for change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_en  <= '0;
            p_seg <= '0;
            p_en  <= '0;
            cnt   <= '0;
        end else begin
            s_seg <= seg_in;
            s_en  <= en_in;
            p_seg <= s_seg;
            p_en  <= s_en;
            if (!same)
                cnt <= 8'd1;
            else if (cnt != 8'hFF)
                cnt <= cnt + 8'd1;
        end
    end

    seg_pattern_decode u_dec (
        .pattern (s_seg),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    always_comb begin
        en8                 = '0;
        en8[NUM_DIGITS-1:0] = s_en;
        same                = ({s_seg, s_en} == {p_seg, p_en});
        en_onehot           = is_onehot(en8);
        en_multi            = (en8 != 8'h00) && !en_onehot;
        cap_idx             = onehot_index(en8);
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:  if (en_onehot) state_nxt = TRACK;
            TRACK: begin
                if (!en_onehot) begin
                    state_nxt = IDLE;
                end else if (same && cnt == CNT_TARGET) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD:  if (!same) state_nxt = en_onehot ? TRACK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mask_upd = frame_mask;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && i == int'(cap_idx)) mask_upd[i] = 1'b1;
        end
    end

    // Capture stage: digit register file, error flags and frame tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bcd_out     <= '0;
            digit_valid <= '0;
            pat_err     <= '0;
            onehot_err  <= 1'b0;
            frame_done  <= 1'b0;
            frame_mask  <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            if (en_multi) onehot_err <= 1'b1;
            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i == int'(cap_idx)) begin
                        bcd_out[4*i +: 4] <= dec_bcd;
                        digit_valid[i]    <= 1'b1;
                        pat_err[i]        <= dec_err;
                    end
                end
                if (&mask_upd) begin
                    frame_done <= 1'b1;
                    frame_mask <= '0;
                end else begin
                    frame_mask <= mask_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: directed sequences, a vector
// table and randomized traffic against a run-length reference model.
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg = '0;
    logic [ND-1:0] dig_en = '0;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] digit_valid, pat_err;
    logic          onehot_err, frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .dig_en      (dig_en),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .pat_err     (pat_err),
        .onehot_err  (onehot_err),
        .frame_done  (frame_done)
    );

    localparam logic [6:0] PATS [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                         7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Reference model state: per-digit results, frame set, current sample and its run length
    logic [3:0]    m_bcd [ND];
    logic [ND-1:0] m_dv, m_pe, m_frame;
    logic          m_oh, m_fd;
    logic [6:0]    sv_seg;
    logic [ND-1:0] sv_en;
    int            run;

    typedef struct {
        logic [6:0] pat;
        int         dig;
        logic [3:0] bcd;
        logic       err;
    } vec_t;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return {4'hF, 1'b0};
        for (int v = 0; v < 10; v++) begin
            if (PATS[v] == p) return {4'(v), 1'b0};
        end
        return {4'hF, 1'b1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({frame_done, onehot_err, pat_err, digit_valid, bcd_out});
    endfunction

    function automatic logic [31:0] model_vec();
        logic [4*ND-1:0] b;
        b = '0;
        for (int i = 0; i < ND; i++) b[4*i +: 4] = m_bcd[i];
        return 32'({m_fd, m_oh, m_pe, m_dv, b});
    endfunction

    // One clock edge of the model: a sample seen SC+1 edges in a row on a single
    // digit is captured, with the result visible after the following edge.
    task automatic model_edge();
        logic [6:0]    in_seg;
        logic [ND-1:0] in_en;
        logic [4:0]    d;
        int            idx;
        in_seg = seg;
        in_en  = dig_en;
`ifdef SEG_ACTIVE_LOW_EN
        in_seg = ~seg;
        in_en  = ~dig_en;
`endif
        m_fd = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) m_bcd[i] = 4'h0;
            m_dv = '0; m_pe = '0; m_frame = '0; m_oh = 1'b0;
            sv_seg = '0; sv_en = '0; run = 0;
            return;
        end
        if ($countones(sv_en) > 1) m_oh = 1'b1;
        if (run == SC + 1 && $countones(sv_en) == 1) begin
            idx = 0;
            for (int i = 0; i < ND; i++) if (sv_en[i]) idx = i;
            d = ref_decode(sv_seg);
            m_bcd[idx]   = d[4:1];
            m_pe[idx]    = d[0];
            m_dv[idx]    = 1'b1;
            m_frame[idx] = 1'b1;
            if (&m_frame) begin
                m_fd    = 1'b1;
                m_frame = '0;
            end
        end
        if ({in_seg, in_en} == {sv_seg, sv_en}) run++;
        else run = 1;
        sv_seg = in_seg;
        sv_en  = in_en;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic drive(input logic [6:0] p, input logic [ND-1:0] e);
`ifdef SEG_ACTIVE_LOW_EN
        seg    = ~p;
        dig_en = ~e;
`else
        seg    = p;
        dig_en = e;
`endif
    endtask

    vec_t tbl [14];
    int   fd_cnt;

    initial begin
        tbl = '{'{7'h7E, 0, 4'h0, 1'b0}, '{7'h30, 1, 4'h1, 1'b0}, '{7'h6D, 2, 4'h2, 1'b0},
                '{7'h79, 3, 4'h3, 1'b0}, '{7'h33, 0, 4'h4, 1'b0}, '{7'h5B, 1, 4'h5, 1'b0},
                '{7'h5F, 2, 4'h6, 1'b0}, '{7'h70, 3, 4'h7, 1'b0}, '{7'h7F, 0, 4'h8, 1'b0},
                '{7'h7B, 1, 4'h9, 1'b0}, '{7'h00, 2, 4'hF, 1'b0}, '{7'h49, 3, 4'hF, 1'b1},
                '{7'h01, 0, 4'hF, 1'b1}, '{7'h7C, 1, 4'hF, 1'b1}};

        rst_n = 1'b0;
        drive(7'h00, '0);
        repeat (3) tick();
        check("reset_state", dut_vec(), 32'h0);
        rst_n = 1'b1;

        // Single held digit: capture visible after edge SC+1
        fd_cnt = 0;
        drive(7'h6D, 4'b0010);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (frame_done) fd_cnt++;
            if (k == SC) check("hold_early_dv", 32'(digit_valid), 32'h0);
            if (k == SC + 1) begin
                check("hold_bcd", 32'(bcd_out[7:4]), 32'h2);
                check("hold_dv", 32'(digit_valid), 32'h2);
            end
        end
        check("hold_no_frame", 32'(fd_cnt), 32'h0);

        // Scan all digits: one frame_done on the last capture
        fd_cnt = 0;
        for (int d = 0; d < ND; d++) begin
            drive(PATS[(d == 0) ? 1 : d + 2], 4'(1 << d));
            for (int k = 0; k < 6; k++) begin
                tick();
                if (frame_done) fd_cnt++;
                if (d == 3 && k == 5) check("scan_frame_edge", 32'(frame_done), 32'h1);
            end
        end
        check("scan_bcd", 32'(bcd_out), 32'h5431);
        check("scan_dv", 32'(digit_valid), 32'hF);
        check("scan_frame_cnt", 32'(fd_cnt), 32'h1);

        // Unstable segments never reach the capture threshold
        for (int k = 0; k < 20; k++) begin
            drive(((k / 2) % 2 == 1) ? 7'h7F : 7'h7E, 4'b0010);
            tick();
        end
        check("toggle_bcd", 32'(bcd_out), 32'h5431);
        check("toggle_dv", 32'(digit_valid), 32'hF);

        // Unknown pattern then blank on digit 0
        drive(7'h49, 4'b0001);
        repeat (6) tick();
        check("bad_pat_bcd", 32'(bcd_out[3:0]), 32'hF);
        check("bad_pat_err", 32'(pat_err[0]), 32'h1);
        drive(7'h00, 4'b0001);
        repeat (6) tick();
        check("blank_bcd", 32'(bcd_out[3:0]), 32'hF);
        check("blank_err", 32'(pat_err[0]), 32'h0);

        // Multi-hot enables, then reset in the middle of a dwell
        drive(7'h5F, 4'b0110);
        repeat (5) tick();
        check("multihot_err", 32'(onehot_err), 32'h1);
        check("multihot_nocap", 32'(bcd_out), 32'h543F);
        drive(7'h5F, 4'b0100);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_clear", dut_vec(), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == SC) check("midreset_early", 32'(digit_valid), 32'h0);
            if (k == SC + 1) begin
                check("midreset_dv", 32'(digit_valid), 32'h4);
                check("midreset_bcd", 32'(bcd_out[11:8]), 32'h6);
            end
        end

        // Decode table across digits
        for (int n = 0; n < 14; n++) begin
            drive(tbl[n].pat, 4'(1 << tbl[n].dig));
            repeat (6) tick();
            check($sformatf("tbl%0d_bcd", n), 32'(bcd_out[4*tbl[n].dig +: 4]), 32'(tbl[n].bcd));
            check($sformatf("tbl%0d_err", n), 32'(pat_err[tbl[n].dig]), 32'(tbl[n].err));
        end

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            int            sel, k, len;
            logic [6:0]    p;
            logic [ND-1:0] e;
            sel = int'($urandom_range(0, 29));
            if (sel == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                e = '0;
                e[$urandom_range(0, ND - 1)] = 1'b1;
                if (sel == 1) e = '0;
                else if (sel == 2) e = 4'($urandom_range(0, 15));
                k = int'($urandom_range(0, 13));
                if (k < 10) p = PATS[k];
                else if (k == 10) p = 7'h00;
                else p = 7'($urandom_range(0, 127));
                len = int'($urandom_range(1, 9));
                drive(p, e);
                repeat (len) tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
